// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the conversion sequencer
//
// Purpose: FSM state encoding, sample width and the DAC mid-scale code used by
// conv_sequencer. Also holds the signed-to-offset-binary conversion helper.
// Ports: none (package).

package conv_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADC  = 2'd1,
    ST_PROC = 2'd2,
    ST_DAC  = 2'd3
  } state_t;

  // Adding mid-scale to a two's-complement word flips its sign bit, which is
  // exactly the offset-binary code the DAC expects (wraps modulo 2^SAMPLE_W).
  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return s + MIDSCALE;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - sample-frame counter producing one tick per frame
//
// Purpose: counts 0..FRAME_DIV-1 while en=1 and wraps; holds at 0 while en=0.
// tick is high for the single cycle in which the count equals FRAME_DIV-1.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   en     in   run enable (synchronous)
//   tick   out  one-cycle frame tick

module frame_timer #(
  parameter int FRAME_DIV = 333
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(FRAME_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - per-frame ADC -> processing -> DAC handshake sequencer
//
// Purpose: on every frame tick, start an ADC frame, pass the converted word to
// the processing stage, convert the signed result to offset binary and start a
// DAC frame. Each handshake wait is bounded by TIMEOUT cycles.
// Optional feature: define CONV_SEQ_OVERRUN_CNT_EN to add the 8-bit saturating
// overrun_cnt output counting dropped frame ticks.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   en                     run enable (synchronous)
//   adc_go / adc_done      ADC frame start pulse / completion pulse
//   adc_data               converted ADC word
//   proc_in / proc_valid   registered ADC word and its valid (held until ready)
//   proc_ready / proc_out  processing accept and signed result (same cycle)
//   dac_go / dac_done      DAC frame start pulse / completion pulse
//   dac_data               registered offset-binary DAC word
//   overrun, timeout_err   sticky status flags (cleared by en=0)
//   overrun_cnt            dropped-tick count (CONV_SEQ_OVERRUN_CNT_EN only)

module conv_sequencer
  import conv_pkg::*;
#(
  parameter int FRAME_DIV = 333,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                adc_go,
  input  logic                adc_done,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic [SAMPLE_W-1:0] proc_in,
  output logic                proc_valid,
  input  logic                proc_ready,
  input  logic [SAMPLE_W-1:0] proc_out,
  output logic                dac_go,
  output logic [SAMPLE_W-1:0] dac_data,
  input  logic                dac_done,
  output logic                overrun,
  output logic                timeout_err
`ifdef CONV_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]          overrun_cnt
`endif
);

  // Wait counter only needs to reach TIMEOUT-1: that is the TIMEOUT-th cycle
  // spent in a state, after which the FSM leaves.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tick;
  logic              at_limit;
  logic              drop;
  logic              timed_out;
  logic              adc_take;
  logic              proc_take;
  logic              overrun_q;
  logic              timeout_q;

  frame_timer #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_timer (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  assign at_limit = (wait_cnt == WAIT_LAST);
  // A tick that finds the FSM busy is discarded; the running frame continues.
  assign drop     = tick && (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Events are tested before the limit so a done/ready arriving in the
  // timeout cycle still completes the handshake.
  always_comb begin
    state_next = state;
    timed_out  = 1'b0;
    adc_take   = 1'b0;
    proc_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_next = ST_ADC;
        end
      end
      ST_ADC: begin
        if (adc_done) begin
          adc_take   = 1'b1;
          state_next = ST_PROC;
        end else if (at_limit) begin
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_PROC: begin
        if (proc_ready) begin
          proc_take  = 1'b1;
          state_next = ST_DAC;
        end else if (at_limit) begin
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DAC: begin
        if (dac_done) begin
          state_next = ST_IDLE;
        end else if (at_limit) begin
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (!en) begin
      state_next = ST_IDLE;
      timed_out  = 1'b0;
      adc_take   = 1'b0;
      proc_take  = 1'b0;
    end
  end

  // Cleared on every state change, so the first cycle of a state sees zero;
  // that first cycle is where the go pulses are issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state_next != state) || (state == ST_IDLE)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (!en) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (timed_out) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Data registers are only written on accepted handshakes, so they keep
  // their contents across en=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proc_in  <= '0;
      dac_data <= MIDSCALE;
    end else begin
      if (adc_take) begin
        proc_in <= adc_data;
      end
      if (proc_take) begin
        dac_data <= to_offset_binary(proc_out);
      end
    end
  end

`ifdef CONV_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt_q <= 8'd0;
    end else if (!en) begin
      overrun_cnt_q <= 8'd0;
    end else if (drop && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_q;
`endif

  // Pulses and valid are decoded from the state register and gated by en so
  // they are low in any cycle where the block is disabled.
  assign adc_go      = en && (state == ST_ADC) && (wait_cnt == '0);
  assign dac_go      = en && (state == ST_DAC) && (wait_cnt == '0);
  assign proc_valid  = en && (state == ST_PROC);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer

module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        adc_go;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic [11:0] proc_in;
  logic        proc_valid;
  logic        proc_ready = 1'b0;
  logic [11:0] proc_out = 12'h000;
  logic        dac_go;
  logic [11:0] dac_data;
  logic        dac_done = 1'b0;
  logic        overrun;
  logic        timeout_err;
`ifdef CONV_SEQ_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  conv_sequencer #(
    .FRAME_DIV (8),
    .TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .adc_go      (adc_go),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .proc_in     (proc_in),
    .proc_valid  (proc_valid),
    .proc_ready  (proc_ready),
    .proc_out    (proc_out),
    .dac_go      (dac_go),
    .dac_data    (dac_data),
    .dac_done    (dac_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
`ifdef CONV_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advances negedge by negedge until adc_go is seen; n = -1 if never seen.
  task automatic wait_adc_go(output int n, output bit saw_dac);
    n = -1;
    saw_dac = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dac_go) saw_dac = 1'b1;
      if (adc_go) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit sd;
    @(negedge clk);
    vectors++; if (adc_go !== 1'b0) begin miscompares++; $display("FAIL rst_adc_go: got %b want 0", adc_go); end
    vectors++; if (dac_go !== 1'b0) begin miscompares++; $display("FAIL rst_dac_go: got %b want 0", dac_go); end
    vectors++; if (proc_valid !== 1'b0) begin miscompares++; $display("FAIL rst_proc_valid: got %b want 0", proc_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    vectors++; if (proc_in !== 12'h000) begin miscompares++; $display("FAIL rst_proc_in: got %h want 000", proc_in); end
    vectors++; if (dac_data !== 12'h800) begin miscompares++; $display("FAIL rst_dac_data: got %h want 800", dac_data); end
    reset = 1'b1;
    en = 1'b1;
    wait_adc_go(n, sd);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL rst_first_adc_go_latency: got %0d want 8", n); end
  endtask

  // Entered on the cycle adc_go is seen; leaves on the next frame's adc_go.
  task automatic do_frame(input logic [11:0] a, input logic [11:0] p, input logic [11:0] exp_dac);
    @(negedge clk);
    vectors++; if (adc_go !== 1'b0) begin miscompares++; $display("FAIL frame_adc_go_width: got %b want 0", adc_go); end
    @(negedge clk);
    @(negedge clk);
    adc_data = a;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    adc_data = 12'h000;
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL frame_proc_valid: got %b want 1", proc_valid); end
    vectors++; if (proc_in !== a) begin miscompares++; $display("FAIL frame_proc_in: got %h want %h", proc_in, a); end
    proc_ready = 1'b1;
    proc_out = p;
    @(negedge clk);
    proc_ready = 1'b0;
    proc_out = 12'h000;
    vectors++; if (proc_valid !== 1'b0) begin miscompares++; $display("FAIL frame_proc_valid_clear: got %b want 0", proc_valid); end
    vectors++; if (dac_go !== 1'b1) begin miscompares++; $display("FAIL frame_dac_go: got %b want 1", dac_go); end
    vectors++; if (dac_data !== exp_dac) begin miscompares++; $display("FAIL frame_dac_data: got %h want %h", dac_data, exp_dac); end
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
    vectors++; if (dac_go !== 1'b0) begin miscompares++; $display("FAIL frame_dac_go_width: got %b want 0", dac_go); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (adc_go !== 1'b1) begin miscompares++; $display("FAIL frame_next_adc_go: got %b want 1", adc_go); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL frame_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_frames();
    do_frame(12'h123, 12'hFFF, 12'h7FF);
    do_frame(12'h456, 12'h7FF, 12'hFFF);
    do_frame(12'h789, 12'h800, 12'h000);
  endtask

  task automatic test_overrun();
    bit early;
    repeat (3) @(negedge clk);
    adc_data = 12'h0F0;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_proc_valid_a: got %b want 1", proc_valid); end
    @(negedge clk);
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_proc_valid_hold: got %b want 1", proc_valid); end
    @(negedge clk);
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_proc_valid_hold2: got %b want 1", proc_valid); end
    proc_ready = 1'b1;
    proc_out = 12'h010;
    @(negedge clk);
    proc_ready = 1'b0;
    vectors++; if (dac_go !== 1'b1) begin miscompares++; $display("FAIL ovr_dac_go: got %b want 1", dac_go); end
    vectors++; if (dac_data !== 12'h810) begin miscompares++; $display("FAIL ovr_dac_data: got %h want 810", dac_data); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_overrun_before: got %b want 0", overrun); end
    early = 1'b0;
    for (int k = 8; k <= 14; k++) begin
      @(negedge clk);
      if (adc_go) early = 1'b1;
      if (k == 8) begin
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_overrun_set: got %b want 1", overrun); end
      end
    end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL ovr_dropped_tick_started_frame: got %b want 0", early); end
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
    @(negedge clk);
    vectors++; if (adc_go !== 1'b1) begin miscompares++; $display("FAIL ovr_next_adc_go: got %b want 1", adc_go); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_overrun_sticky: got %b want 1", overrun); end
`ifdef CONV_SEQ_OVERRUN_CNT_EN
    vectors++; if (overrun_cnt !== 8'd1) begin miscompares++; $display("FAIL ovr_overrun_cnt: got %0d want 1", overrun_cnt); end
`endif
  endtask

  task automatic test_en_drop();
    int n;
    bit sd;
    repeat (3) @(negedge clk);
    adc_data = 12'hABC;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL en_proc_valid_before: got %b want 1", proc_valid); end
    vectors++; if (proc_in !== 12'hABC) begin miscompares++; $display("FAIL en_proc_in: got %h want abc", proc_in); end
    en = 1'b0;
    @(negedge clk);
    vectors++; if (proc_valid !== 1'b0) begin miscompares++; $display("FAIL en_proc_valid_after: got %b want 0", proc_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL en_overrun_clear: got %b want 0", overrun); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL en_timeout_clear: got %b want 0", timeout_err); end
    proc_ready = 1'b1;
    proc_out = 12'h123;
    @(negedge clk);
    proc_ready = 1'b0;
    vectors++; if (dac_data !== 12'h810) begin miscompares++; $display("FAIL en_dac_data_hold: got %h want 810", dac_data); end
    vectors++; if (proc_in !== 12'hABC) begin miscompares++; $display("FAIL en_proc_in_hold: got %h want abc", proc_in); end
    vectors++; if (dac_go !== 1'b0) begin miscompares++; $display("FAIL en_dac_go: got %b want 0", dac_go); end
`ifdef CONV_SEQ_OVERRUN_CNT_EN
    vectors++; if (overrun_cnt !== 8'd0) begin miscompares++; $display("FAIL en_overrun_cnt_clear: got %0d want 0", overrun_cnt); end
`endif
    en = 1'b1;
    wait_adc_go(n, sd);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL en_restart_latency: got %0d want 8", n); end
  endtask

  task automatic test_event_wins();
    int n;
    bit sd;
    repeat (63) @(negedge clk);
    adc_data = 12'h5A5;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    vectors++; if (proc_valid !== 1'b1) begin miscompares++; $display("FAIL win_proc_valid: got %b want 1", proc_valid); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL win_timeout_err: got %b want 0", timeout_err); end
    vectors++; if (proc_in !== 12'h5A5) begin miscompares++; $display("FAIL win_proc_in: got %h want 5a5", proc_in); end
    proc_ready = 1'b1;
    proc_out = 12'h0A5;
    @(negedge clk);
    proc_ready = 1'b0;
    vectors++; if (dac_data !== 12'h8A5) begin miscompares++; $display("FAIL win_dac_data: got %h want 8a5", dac_data); end
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
    wait_adc_go(n, sd);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL win_next_adc_go: got %0d want 6", n); end
  endtask

  task automatic test_timeout();
    int n;
    bit sd;
    bit stray;
    stray = 1'b0;
    proc_ready = 1'b1;
    dac_done = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      if (adc_go || dac_go || proc_valid) stray = 1'b1;
    end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_err_early: got %b want 0", timeout_err); end
    vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL to_stray_outputs: got %b want 0", stray); end
    @(negedge clk);
    proc_ready = 1'b0;
    dac_done = 1'b0;
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    wait_adc_go(n, sd);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL to_next_adc_go: got %0d want 8", n); end
    vectors++; if (sd !== 1'b0) begin miscompares++; $display("FAIL to_no_dac_go: got %b want 0", sd); end
  endtask

  task automatic test_reset_mid_dac();
    int n;
    bit sd;
    repeat (3) @(negedge clk);
    adc_data = 12'h321;
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    proc_ready = 1'b1;
    proc_out = 12'h001;
    @(negedge clk);
    proc_ready = 1'b0;
    vectors++; if (dac_data !== 12'h801) begin miscompares++; $display("FAIL rd_dac_data_before: got %h want 801", dac_data); end
    reset = 1'b0;
    #1;
    vectors++; if (dac_go !== 1'b0) begin miscompares++; $display("FAIL rd_dac_go: got %b want 0", dac_go); end
    vectors++; if (dac_data !== 12'h800) begin miscompares++; $display("FAIL rd_dac_data: got %h want 800", dac_data); end
    vectors++; if (proc_in !== 12'h000) begin miscompares++; $display("FAIL rd_proc_in: got %h want 000", proc_in); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rd_overrun: got %b want 0", overrun); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rd_timeout_err: got %b want 0", timeout_err); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_adc_go(n, sd);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL rd_first_adc_go: got %0d want 8", n); end
    vectors++; if (sd !== 1'b0) begin miscompares++; $display("FAIL rd_trailing_dac_go: got %b want 0", sd); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_overrun();
    test_en_drop();
    test_event_wins();
    test_timeout();
    test_reset_mid_dac();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
